// File: rtl/led_status_decoder_pkg.sv
// Shared definitions for the LED status bus.
// Used by the producer top and by the receive-side decoder.
// Contents:
//   - producer state encodings;
//   - the four leds[7:4] pattern codes;
//   - err_code bit positions;
//   - lock FSM encodings;
//   - the legal-transition helper.
package led_status_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_DISPLAY = 2'd2,
    ST_RESET   = 2'd3
  } prod_state_e;

  localparam logic [3:0] PAT_IDLE    = 4'b0001;
  localparam logic [3:0] PAT_COUNT   = 4'b0011;
  localparam logic [3:0] PAT_DISPLAY = 4'b0111;
  localparam logic [3:0] PAT_RESET   = 4'b1111;

  localparam int ERR_BUS   = 0;
  localparam int ERR_SEQ   = 1;
  localparam int ERR_TRANS = 2;

  typedef enum logic [1:0] {
    LK_UNLOCKED = 2'd0,
    LK_LOCKING  = 2'd1,
    LK_LOCKED   = 2'd2
  } lock_e;

  // The producer cycles IDLE -> COUNT -> DISPLAY -> RESET_ST -> IDLE.
  // This is a +1 step in the 2-bit encoding, so the wrap back to IDLE comes for free.
  // Holding the current state is always legal.
  function automatic logic trans_ok(input logic [1:0] from_st,
                                    input logic [1:0] to_st);
    logic [1:0] step_st;
    step_st = from_st + 2'd1;
    return (to_st == from_st) || (to_st == step_st);
  endfunction

endpackage

// File: rtl/led_status_decoder_pattern_decode.sv
// led_pattern_decode: combinational decode of the leds[7:4] thermometer pattern.
// Ports:
//   pattern  in   4  leds[7:4] from the producer
//   valid    out  1  pattern is one of the four legal codes
//   state    out  2  producer state implied by the pattern
//                    (ST_IDLE when the pattern is not valid)
module led_pattern_decode
  import led_status_decoder_pkg::*;
(
  input  logic [3:0] pattern,
  output logic       valid,
  output logic [1:0] state
);

  always_comb begin
    valid = 1'b1;
    state = ST_IDLE;
    case (pattern)
      PAT_IDLE:    state = ST_IDLE;
      PAT_COUNT:   state = ST_COUNT;
      PAT_DISPLAY: state = ST_DISPLAY;
      PAT_RESET:   state = ST_RESET;
      default:     valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_status_decoder.sv
// led_status_decoder: receive-side decoder for the LED status bus.
// Recovers the producer state and the 8-bit count from {leds, counter_out, state_out}.
// Checks bus consistency, count sequence and state transitions.
// Tracks lock status.
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous active-low reset
//   in_valid     in   1      sample strobe
//   leds         in   8      {pattern[3:0], count[3:0]}
//   counter_out  in   4      producer count low nibble
//   state_out    in   2      producer state
//   clear        in   1      synchronous clear of err_code / err_count
//   dec_state    out  2      decoded state of the last accepted sample
//   count_est    out  8      reconstructed producer count
//   locked       out  1      lock FSM is LOCKED
//   err_pulse    out  1      one-cycle flag: the last sample had an error
//   err_code     out  3      sticky {transition, sequence, bus} error flags
//   err_count    out  ERR_W  saturating count of erroneous samples
module led_status_decoder
  import led_status_decoder_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       leds,
  input  logic [3:0]       counter_out,
  input  logic [1:0]       state_out,
  input  logic             clear,
  output logic [1:0]       dec_state,
  output logic [7:0]       count_est,
  output logic             locked,
  output logic             err_pulse,
  output logic [2:0]       err_code,
  output logic [ERR_W-1:0] err_count
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  logic             pat_valid;
  logic [1:0]       pat_state;
  logic             quiet;
  logic [3:0]       nib;
  logic [3:0]       prev_nib;
  logic [2:0]       err_flags;
  logic             any_err;
  logic             nib_wrap;
  logic [3:0]       cnt_hi;
  logic [RUN_W-1:0] run_inc;

  logic [1:0]       dec_state_q, dec_state_d;
  logic [7:0]       count_est_q, count_est_d;
  logic             prev_valid_q, prev_valid_d;
  logic             err_pulse_q, err_pulse_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [RUN_W-1:0] run_q, run_d;
  lock_e            lock_q, lock_d;

  led_pattern_decode u_pattern_decode (
    .pattern (leds[7:4]),
    .valid   (pat_valid),
    .state   (pat_state)
  );

  // An all-zero bus means the producer is held in reset.
  // That is a resync point, not an error.
  assign quiet    = (leds == 8'h00) && (counter_out == 4'h0) && (state_out == 2'b00);
  assign nib      = leds[3:0];
  // The previous accepted nibble and state live in the output registers.
  assign prev_nib = count_est_q[3:0];

  assign err_flags[ERR_BUS]   = !quiet &&
                                (!pat_valid || (nib != counter_out) || (pat_state != state_out));
  assign err_flags[ERR_SEQ]   = prev_valid_q && !quiet &&
                                (nib != prev_nib) && (nib != prev_nib + 4'd1);
  assign err_flags[ERR_TRANS] = prev_valid_q && !quiet && pat_valid &&
                                !trans_ok(dec_state_q, pat_state);
  assign any_err = |err_flags;

  // High nibble restarts at 0 after a resync.
  // Otherwise it advances only on the 15 -> 0 rollover.
  assign nib_wrap = prev_valid_q && (prev_nib == 4'hF) && (nib == 4'h0);
  assign cnt_hi   = !prev_valid_q ? 4'h0 :
                    nib_wrap      ? count_est_q[7:4] + 4'd1 : count_est_q[7:4];
  assign run_inc  = run_q + 1'b1;

  always_comb begin
    dec_state_d  = dec_state_q;
    count_est_d  = count_est_q;
    prev_valid_d = prev_valid_q;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    err_count_d  = err_count_q;
    run_d        = run_q;
    lock_d       = lock_q;

    if (in_valid) begin
      err_pulse_d = any_err;

      // On a pattern error the state and count are unknown, so they hold.
      if (quiet) begin
        dec_state_d  = ST_IDLE;
        count_est_d  = 8'h00;
        prev_valid_d = 1'b0;
      end else if (pat_valid) begin
        dec_state_d  = pat_state;
        count_est_d  = {cnt_hi, nib};
        prev_valid_d = 1'b1;
      end

      if (quiet || any_err) begin
        lock_d = LK_UNLOCKED;
        run_d  = '0;
      end else begin
        case (lock_q)
          LK_UNLOCKED: begin
            run_d  = RUN_W'(1);
            lock_d = (LOCK_COUNT <= 1) ? LK_LOCKED : LK_LOCKING;
          end
          LK_LOCKING: begin
            run_d = run_inc;
            if (run_inc >= RUN_W'(LOCK_COUNT)) lock_d = LK_LOCKED;
          end
          LK_LOCKED: lock_d = LK_LOCKED;
          default: begin
            lock_d = LK_UNLOCKED;
            run_d  = '0;
          end
        endcase
      end
    end

    // clear overrides a same-cycle error.
    // err_pulse and the lock FSM still react to that error above.
    if (clear) begin
      err_code_d  = 3'b000;
      err_count_d = '0;
    end else if (in_valid && any_err) begin
      err_code_d = err_code_q | err_flags;
      if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_state_q  <= 2'b00;
      count_est_q  <= 8'h00;
      prev_valid_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= 3'b000;
      err_count_q  <= '0;
      run_q        <= '0;
      lock_q       <= LK_UNLOCKED;
    end else begin
      dec_state_q  <= dec_state_d;
      count_est_q  <= count_est_d;
      prev_valid_q <= prev_valid_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      err_count_q  <= err_count_d;
      run_q        <= run_d;
      lock_q       <= lock_d;
    end
  end

  assign dec_state = dec_state_q;
  assign count_est = count_est_q;
  assign locked    = (lock_q == LK_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

endmodule
